// File: rtl/mfcc_sequencer.sv
// Frame-level controller for the MFCC pipeline: sequences Hamming, FFT, Mel and DCT
// for each frame, slides the window buffer, tracks one pending frame and watchdogs each stage.
module mfcc_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES    = 20000,
    parameter int unsigned WDOG_WIDTH        = 16,
    parameter int unsigned FRAME_COUNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable_i,
    input  logic                         clear_i,
    input  logic                         frame_ready_i,
    input  logic                         hamming_done_i,
    input  logic                         fft_done_i,
    input  logic                         mel_done_i,
    input  logic                         dct_done_i,
    output logic                         start_hamming_o,
    output logic                         start_fft_o,
    output logic                         start_mel_o,
    output logic                         start_dct_o,
    output logic                         start_move_o,
    output logic                         frame_done_o,
    output logic                         busy_o,
    output logic [2:0]                   stage_o,
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count_o,
    output logic                         overrun_o,
    output logic                         error_o,
    output logic [2:0]                   error_stage_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_HAM  = 3'd2,
        S_FFT  = 3'd3,
        S_MEL  = 3'd4,
        S_DCT  = 3'd5,
        S_ADV  = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    localparam bit WDOG_ON = (TIMEOUT_CYCLES != 0);
    localparam logic [WDOG_WIDTH-1:0] WDOG_LAST =
        WDOG_ON ? WDOG_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    state_t                         state_q, state_d;
    logic                           pending_q, pending_d;
    logic [WDOG_WIDTH-1:0]          wdog_q, wdog_d;
    logic                           overrun_q, overrun_d;
    logic                           error_q, error_d;
    logic [2:0]                     err_stage_q, err_stage_d;
    logic [FRAME_COUNT_WIDTH-1:0]   count_q, count_d;
    logic                           start_ham_q, start_ham_d;
    logic                           start_fft_q, start_fft_d;
    logic                           start_mel_q, start_mel_d;
    logic                           start_dct_q, start_dct_d;
    logic                           move_q, move_d;
    logic                           fdone_q, fdone_d;
    logic                           busy_q, busy_d;

    logic in_stage;
    logic frame_active;
    logic stage_done;
    logic stage_first;
    logic wdog_counting;
    logic wdog_fire;

    assign in_stage     = (state_q inside {S_HAM, S_FFT, S_MEL, S_DCT});
    assign frame_active = (state_q inside {S_HAM, S_FFT, S_MEL, S_DCT, S_ADV});
    // The start pulse cycle is the first cycle of a stage; the count only begins after it,
    // so a stage is allowed TIMEOUT_CYCLES cycles from its start pulse to its done pulse.
    assign stage_first   = start_ham_q | start_fft_q | start_mel_q | start_dct_q;
    assign wdog_counting = WDOG_ON && in_stage && !stage_first;
    assign wdog_fire     = wdog_counting && !stage_done && (wdog_q == WDOG_LAST);

    always_comb begin
        stage_done = 1'b0;
        unique case (state_q)
            S_HAM:   stage_done = hamming_done_i;
            S_FFT:   stage_done = fft_done_i;
            S_MEL:   stage_done = mel_done_i;
            S_DCT:   stage_done = dct_done_i;
            default: stage_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        wdog_d      = '0;
        overrun_d   = overrun_q & ~clear_i;
        error_d     = error_q & ~clear_i;
        err_stage_d = err_stage_q;
        count_d     = count_q;
        start_ham_d = 1'b0;
        start_fft_d = 1'b0;
        start_mel_d = 1'b0;
        start_dct_d = 1'b0;
        move_d      = 1'b0;
        fdone_d     = 1'b0;

        if (frame_active && frame_ready_i) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (frame_ready_i || pending_q) begin
                    state_d     = S_HAM;
                    start_ham_d = 1'b1;
                    // A pending frame and a fresh one together: run one, keep the other queued.
                    pending_d   = pending_q & frame_ready_i;
                end else if (!enable_i) begin
                    state_d = S_IDLE;
                end
            end
            S_HAM: begin
                if (hamming_done_i) begin
                    state_d     = S_FFT;
                    start_fft_d = 1'b1;
                end
            end
            S_FFT: begin
                if (fft_done_i) begin
                    state_d     = S_MEL;
                    start_mel_d = 1'b1;
                end
            end
            S_MEL: begin
                if (mel_done_i) begin
                    state_d     = S_DCT;
                    start_dct_d = 1'b1;
                end
            end
            S_DCT: begin
                if (dct_done_i) begin
                    state_d = S_ADV;
                    move_d  = 1'b1;
                    fdone_d = 1'b1;
                    count_d = count_q + FRAME_COUNT_WIDTH'(1);
                end
            end
            S_ADV: begin
                state_d = enable_i ? S_WAIT : S_IDLE;
            end
            S_ERR: begin
                if (clear_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (wdog_fire) begin
            state_d     = S_ERR;
            pending_d   = 1'b0;
            error_d     = 1'b1;
            err_stage_d = state_q;
        end

        if (wdog_counting && (state_d == state_q)) begin
            wdog_d = wdog_q + WDOG_WIDTH'(1);
        end
    end

    assign busy_d = (state_d inside {S_HAM, S_FFT, S_MEL, S_DCT, S_ADV});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            wdog_q      <= '0;
            overrun_q   <= 1'b0;
            error_q     <= 1'b0;
            err_stage_q <= 3'd0;
            count_q     <= '0;
            start_ham_q <= 1'b0;
            start_fft_q <= 1'b0;
            start_mel_q <= 1'b0;
            start_dct_q <= 1'b0;
            move_q      <= 1'b0;
            fdone_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            wdog_q      <= wdog_d;
            overrun_q   <= overrun_d;
            error_q     <= error_d;
            err_stage_q <= err_stage_d;
            count_q     <= count_d;
            start_ham_q <= start_ham_d;
            start_fft_q <= start_fft_d;
            start_mel_q <= start_mel_d;
            start_dct_q <= start_dct_d;
            move_q      <= move_d;
            fdone_q     <= fdone_d;
            busy_q      <= busy_d;
        end
    end

    assign start_hamming_o = start_ham_q;
    assign start_fft_o     = start_fft_q;
    assign start_mel_o     = start_mel_q;
    assign start_dct_o     = start_dct_q;
    assign start_move_o    = move_q;
    assign frame_done_o    = fdone_q;
    assign busy_o          = busy_q;
    assign stage_o         = state_q;
    assign frame_count_o   = count_q;
    assign overrun_o       = overrun_q;
    assign error_o         = error_q;
    assign error_stage_o   = err_stage_q;

endmodule

// File: tb/tb_mfcc_sequencer.sv
// Bench for mfcc_sequencer: directed scenarios followed by random traffic, all cycles
// compared against a frame/stage-level reference model.
module tb_mfcc_sequencer;

    localparam int TO  = 8;
    localparam int FCW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           clr = 1'b0;
    logic           fr = 1'b0;
    logic [3:0]     dn = 4'b0000;

    logic           start_hamming_o, start_fft_o, start_mel_o, start_dct_o;
    logic           start_move_o, frame_done_o, busy_o;
    logic [2:0]     stage_o;
    logic [FCW-1:0] frame_count_o;
    logic           overrun_o, error_o;
    logic [2:0]     error_stage_o;

    int errors = 0;
    int checks = 0;

    mfcc_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .WDOG_WIDTH(4),
        .FRAME_COUNT_WIDTH(FCW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable_i(en),
        .clear_i(clr),
        .frame_ready_i(fr),
        .hamming_done_i(dn[0]),
        .fft_done_i(dn[1]),
        .mel_done_i(dn[2]),
        .dct_done_i(dn[3]),
        .start_hamming_o(start_hamming_o),
        .start_fft_o(start_fft_o),
        .start_mel_o(start_mel_o),
        .start_dct_o(start_dct_o),
        .start_move_o(start_move_o),
        .frame_done_o(frame_done_o),
        .busy_o(busy_o),
        .stage_o(stage_o),
        .frame_count_o(frame_count_o),
        .overrun_o(overrun_o),
        .error_o(error_o),
        .error_stage_o(error_stage_o)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 waiting, 2 running stage m_stg, 3 advancing, 4 error.
    int       m_mode, m_stg, m_elapsed, m_estage, m_count;
    bit       m_pend, m_ovr, m_err, m_move, m_fdone;
    bit [3:0] m_start;

    function automatic int exp_stage();
        case (m_mode)
            0:       return 0;
            1:       return 1;
            2:       return 2 + m_stg;
            3:       return 6;
            default: return 7;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_stg = 0; m_elapsed = 0; m_estage = 0; m_count = 0;
        m_pend = 0; m_ovr = 0; m_err = 0; m_move = 0; m_fdone = 0; m_start = '0;
    endtask

    task automatic model_step();
        bit [3:0] st;
        bit mv, fd;
        st = '0; mv = 0; fd = 0;
        if (clr) begin
            m_ovr = 0;
            m_err = 0;
        end
        if ((m_mode == 2 || m_mode == 3) && fr) begin
            if (m_pend) m_ovr = 1;
            else        m_pend = 1;
        end
        case (m_mode)
            0: if (en) m_mode = 1;
            1: begin
                if (fr || m_pend) begin
                    m_pend = m_pend && fr;
                    m_mode = 2; m_stg = 0; m_elapsed = 0; st[0] = 1;
                end else if (!en) begin
                    m_mode = 0;
                end
            end
            2: begin
                if (dn[m_stg]) begin
                    if (m_stg == 3) begin
                        m_mode = 3; mv = 1; fd = 1;
                        m_count = (m_count + 1) % (1 << FCW);
                    end else begin
                        m_stg = m_stg + 1; m_elapsed = 0; st[m_stg] = 1;
                    end
                end else if (m_elapsed == TO) begin
                    m_mode = 4; m_pend = 0; m_err = 1; m_estage = 2 + m_stg;
                end else begin
                    m_elapsed = m_elapsed + 1;
                end
            end
            3: m_mode = en ? 1 : 0;
            default: if (clr) m_mode = 0;
        endcase
        m_start = st; m_move = mv; m_fdone = fd;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("start_hamming", 32'(start_hamming_o), 32'(m_start[0]));
        chk("start_fft",     32'(start_fft_o),     32'(m_start[1]));
        chk("start_mel",     32'(start_mel_o),     32'(m_start[2]));
        chk("start_dct",     32'(start_dct_o),     32'(m_start[3]));
        chk("start_move",    32'(start_move_o),    32'(m_move));
        chk("frame_done",    32'(frame_done_o),    32'(m_fdone));
        chk("busy",          32'(busy_o),          32'(m_mode == 2 || m_mode == 3));
        chk("stage",         32'(stage_o),         32'(exp_stage()));
        chk("frame_count",   32'(frame_count_o),   32'(m_count));
        chk("overrun",       32'(overrun_o),       32'(m_ovr));
        chk("error",         32'(error_o),         32'(m_err));
        chk("error_stage",   32'(error_stage_o),   32'(m_estage));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        fr = 0; clr = 0; dn = '0;
    endtask

    task automatic run_stage(input int k, input int dly);
        repeat (dly) cyc();
        dn[k] = 1'b1;
        cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fr = 0; clr = 0; dn = '0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();

        // Nominal frame, each done 5 cycles after its start
        en = 1; cyc();
        chk("nom_wait", 32'(stage_o), 32'd1);
        repeat (3) cyc();
        fr = 1; cyc();
        chk("nom_start_ham", 32'(start_hamming_o), 32'd1);
        run_stage(0, 5);
        chk("nom_start_fft", 32'(start_fft_o), 32'd1);
        run_stage(1, 5);
        chk("nom_start_mel", 32'(start_mel_o), 32'd1);
        run_stage(2, 5);
        chk("nom_start_dct", 32'(start_dct_o), 32'd1);
        run_stage(3, 5);
        chk("nom_frame_done", 32'(frame_done_o), 32'd1);
        chk("nom_move", 32'(start_move_o), 32'd1);
        chk("nom_count", 32'(frame_count_o), 32'd1);
        cyc();
        chk("nom_done_pulse_end", 32'(frame_done_o), 32'd0);

        // Back-to-back frames with one dropped
        do_reset();
        en = 1; cyc();
        fr = 1; cyc();
        cyc();
        fr = 1; cyc();
        run_stage(0, 3);
        fr = 1; cyc();
        chk("b2b_overrun", 32'(overrun_o), 32'd1);
        run_stage(1, 2); run_stage(2, 2); run_stage(3, 2);
        chk("b2b_adv", 32'(stage_o), 32'd6);
        cyc();
        chk("b2b_wait", 32'(stage_o), 32'd1);
        cyc();
        chk("b2b_restart", 32'(start_hamming_o), 32'd1);
        run_stage(0, 1); run_stage(1, 1); run_stage(2, 1); run_stage(3, 1);
        repeat (4) cyc();
        chk("b2b_count", 32'(frame_count_o), 32'd2);
        chk("b2b_idle_wait", 32'(stage_o), 32'd1);

        // Watchdog on a hung FFT
        do_reset();
        en = 1; cyc();
        fr = 1; cyc();
        run_stage(0, 3);
        chk("wd_start_fft", 32'(start_fft_o), 32'd1);
        repeat (8) cyc();
        chk("wd_pre_fire", 32'(stage_o), 32'd3);
        cyc();
        chk("wd_stage", 32'(stage_o), 32'd7);
        chk("wd_error", 32'(error_o), 32'd1);
        chk("wd_error_stage", 32'(error_stage_o), 32'd3);
        fr = 1; dn = 4'b1111; cyc();
        repeat (3) cyc();
        chk("wd_no_starts", 32'({start_hamming_o, start_fft_o, start_mel_o, start_dct_o}), 32'd0);
        clr = 1; cyc();
        chk("wd_clear_stage", 32'(stage_o), 32'd0);
        chk("wd_clear_error", 32'(error_o), 32'd0);

        // Mel done on the last allowed cycle
        do_reset();
        en = 1; cyc();
        fr = 1; cyc();
        run_stage(0, 2); run_stage(1, 2);
        run_stage(2, 8);
        chk("race_start_dct", 32'(start_dct_o), 32'd1);
        chk("race_no_error", 32'(error_o), 32'd0);

        // Graceful disable during MEL
        do_reset();
        en = 1; cyc();
        fr = 1; cyc();
        run_stage(0, 2); run_stage(1, 2);
        en = 0; cyc();
        run_stage(2, 2); run_stage(3, 2);
        chk("dis_frame_done", 32'(frame_done_o), 32'd1);
        chk("dis_adv", 32'(stage_o), 32'd6);
        cyc();
        chk("dis_idle", 32'(stage_o), 32'd0);
        fr = 1; cyc();
        cyc();
        chk("dis_ignored", 32'(stage_o), 32'd0);
        chk("dis_no_start", 32'(start_hamming_o), 32'd0);

        // Asynchronous reset during DCT, then a stray done
        do_reset();
        en = 1; cyc();
        fr = 1; cyc();
        run_stage(0, 1); run_stage(1, 1); run_stage(2, 1); run_stage(3, 1);
        cyc();
        fr = 1; cyc();
        run_stage(0, 1); run_stage(1, 1); run_stage(2, 1);
        cyc();
        chk("rst_in_dct", 32'(stage_o), 32'd5);
        chk("rst_pre_count", 32'(frame_count_o), 32'd1);
        do_reset();
        chk("rst_count_zero", 32'(frame_count_o), 32'd0);
        en = 1; cyc();
        chk("rst_wait", 32'(stage_o), 32'd1);
        dn[3] = 1; cyc();
        chk("rst_stray_done", 32'(frame_done_o), 32'd0);
        chk("rst_stray_stage", 32'(stage_o), 32'd1);

        // Random traffic
        do_reset();
        en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) en = ~en;
            fr  = ($urandom_range(0, 19) == 0);
            clr = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < 4; k++) dn[k] = ($urandom_range(0, 6) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
